// File: rtl/uart_tx_frame.sv
// uart_tx_frame: configurable UART transmitter (start, DATA_BITS LSB-first,
// optional parity, 1-2 stop bits) with a valid/ready input handshake and an
// internal baud divider. Back-to-back frames are accepted in the last clock
// of the final stop bit, so the line never idles between streamed words.
module uart_tx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    // Bit counter covers both data bits and stop bits (STOP_BITS <= 2 < DATA_BITS).
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                state, state_d;
    logic [BAUD_W-1:0]     baud_cnt, baud_d;
    logic [BIT_W-1:0]      bit_cnt, bit_d;
    logic [DATA_BITS-1:0]  shreg, shreg_d;
    logic                  par_bit, par_d;
    logic                  tx_d;
    logic                  baud_end;
    logic                  last_stop;
    logic                  hs;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign last_stop = (state == STOP) && baud_end && (bit_cnt == STOP_LAST);

    // Ready and done come from registered state only, never from tx_valid.
    assign tx_ready = (state == IDLE) || last_stop;
    assign tx_done  = last_stop;
    assign tx_busy  = (state != IDLE);
    assign hs       = tx_valid && tx_ready;

    // Next-state, counters, shift register and the next line level.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        par_d   = par_bit;
        tx_d    = 1'b1;

        unique case (state)
            IDLE: ;
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            PAR: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_cnt == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake overrides everything, including the last stop clock.
        if (hs) begin
            shreg_d = tx_data;
            par_d   = (PARITY == 2) ? ^tx_data : ~^tx_data;
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
        end

        // Line level is derived from the upcoming state so tx is a clean flop.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State, counters, data and line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            par_bit  <= par_d;
            tx       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitter configurations (8E1/4, 7O2/3, 8N1/2,
// 8N1/4) driven from a vector table, random words and hand-written corner
// sequences; a frame-level model builds the expected bit list per word.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] vld = '0;
    logic [3:0] rdy, txo, bsy, dn;
    logic [8:0] dat [4];

    int tests = 0;
    int fails = 0;

    int cfg_db  [4] = '{8, 7, 8, 8};
    int cfg_cpb [4] = '{4, 3, 2, 4};
    int cfg_par [4] = '{2, 1, 0, 0};
    int cfg_sb  [4] = '{1, 2, 1, 1};

    logic mbits [64];
    int   mlen;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_data(dat[0][7:0]),
        .tx(txo[0]), .tx_busy(bsy[0]), .tx_done(dn[0]));
    uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_data(dat[1][6:0]),
        .tx(txo[1]), .tx_busy(bsy[1]), .tx_done(dn[1]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) u_8n1_2 (
        .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_data(dat[2][7:0]),
        .tx(txo[2]), .tx_busy(bsy[2]), .tx_done(dn[2]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1_4 (
        .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_data(dat[3][7:0]),
        .tx(txo[3]), .tx_busy(bsy[3]), .tx_done(dn[3]));

    typedef struct {
        int         k;
        logic [8:0] d;
        int         len;   // expected clocks from handshake to tx_done
    } vec_t;

    task automatic check(input string nm, input int k, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst=%0d clk=%0d got=%0h want=%0h", nm, k, c, act, exp);
        end
    endtask

    // Expected line bits for one word, appended at index base.
    task automatic model_frame(input int k, input logic [8:0] d, input int base);
        int n;
        int ones;
        n    = base;
        ones = 0;
        mbits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < cfg_db[k]; i++) begin
            mbits[n] = d[i];
            ones = ones + int'(d[i]);
            n = n + 1;
        end
        if (cfg_par[k] == 2) begin
            mbits[n] = ((ones % 2) == 1);
            n = n + 1;
        end else if (cfg_par[k] == 1) begin
            mbits[n] = ((ones % 2) == 0);
            n = n + 1;
        end
        for (int i = 0; i < cfg_sb[k]; i++) begin
            mbits[n] = 1'b1;
            n = n + 1;
        end
        mlen = n;
    endtask

    // One frame from an idle instance; optional mid-frame valid pulse with new data.
    task automatic run_frame(input int k, input logic [8:0] d, input int len, input bit disturb);
        int cpb;
        cpb = cfg_cpb[k];
        model_frame(k, d, 0);
        @(posedge clk); #1;
        check("ready_idle", k, 0, rdy[k], 1);
        vld[k] = 1'b1;
        dat[k] = d;
        @(posedge clk); #1;
        vld[k] = 1'b0;
        dat[k] = ~d;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            check("tx", k, c, txo[k], mbits[(c - 1) / cpb]);
            check("done", k, c, dn[k], (c == len));
            check("ready", k, c, rdy[k], (c == len));
            check("busy", k, c, bsy[k], 1);
            @(posedge clk); #1;
            if (disturb && c == 10) begin
                vld[k] = 1'b1;
                dat[k] = d ^ 9'h0F0;
            end
            if (disturb && c == 11) vld[k] = 1'b0;
        end
        @(negedge clk);
        check("idle_tx", k, len + 1, txo[k], 1);
        check("idle_busy", k, len + 1, bsy[k], 0);
        check("idle_done", k, len + 1, dn[k], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [6];
        int   dones;
        int   k;
        logic [8:0] d;

        tbl[0] = '{0, 9'h0A5, 44};
        tbl[1] = '{1, 9'h07F, 33};
        tbl[2] = '{0, 9'h001, 44};
        tbl[3] = '{1, 9'h000, 33};
        tbl[4] = '{2, 9'h0C3, 20};
        tbl[5] = '{3, 9'h03C, 40};
        for (int i = 0; i < 4; i++) dat[i] = '0;

        // Reset state, sampled while reset is still asserted.
        #12;
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", i, 0, txo[i], 1);
            check("rst_busy", i, 0, bsy[i], 0);
            check("rst_done", i, 0, dn[i], 0);
            check("rst_ready", i, 0, rdy[i], 1);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 6; i++) run_frame(tbl[i].k, tbl[i].d, tbl[i].len, 1'b0);

        // Random words on random configurations.
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 3);
            d = 9'($urandom);
            d = d & 9'((1 << cfg_db[k]) - 1);
            model_frame(k, d, 0);
            run_frame(k, d, mlen * cfg_cpb[k], 1'b0);
        end

        // Mid-frame valid pulse with different data is ignored.
        run_frame(3, 9'h055, 40, 1'b1);

        // Back-to-back: valid held high across two words, no idle gap.
        model_frame(2, 9'h000, 0);
        model_frame(2, 9'h0FF, mlen);
        dones = 0;
        @(posedge clk); #1;
        vld[2] = 1'b1;
        dat[2] = 9'h000;
        @(posedge clk); #1;
        dat[2] = 9'h0FF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check("b2b_tx", 2, c, txo[2], mbits[(c - 1) / 2]);
            check("b2b_busy", 2, c, bsy[2], 1);
            check("b2b_ready", 2, c, rdy[2], (c == 20 || c == 40));
            if (dn[2]) dones++;
            @(posedge clk); #1;
            if (c == 20) vld[2] = 1'b0;
        end
        @(negedge clk);
        check("b2b_dones", 2, 41, dones, 2);
        check("b2b_idle_busy", 2, 41, bsy[2], 0);
        check("b2b_idle_tx", 2, 41, txo[2], 1);

        // Reset at clock 17 of a frame aborts it immediately.
        @(posedge clk); #1;
        vld[3] = 1'b1;
        dat[3] = 9'h012;
        @(posedge clk); #1;
        vld[3] = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("pre_rst_busy", 3, 17, bsy[3], 1);
        rst = 1'b1;
        #1;
        check("abort_tx", 3, 17, txo[3], 1);
        check("abort_ready", 3, 17, rdy[3], 1);
        check("abort_busy", 3, 17, bsy[3], 0);
        check("abort_done", 3, 17, dn[3], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dn[3]) dones++;
        end
        check("abort_no_done", 3, 0, dones, 0);
        run_frame(3, 9'h03C, 40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
